// File: rtl/load_store_unit.sv
// Byte-wide memory load/store unit: serves byte and little-endian halfword requests one at a time.
// Optional build macro LSU_ALIGN_CHECK_EN rejects odd-address halfwords with resp_err instead of executing them.
module load_store_unit #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic              req_half,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [15:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [15:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;

  state_t            state_q, state_d;
  logic              we_q, we_d;
  logic              half_q, half_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       wdata_q, wdata_d;
  logic [15:0]       rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              misaligned;

`ifdef LSU_ALIGN_CHECK_EN
  assign misaligned = req_half & req_addr[0];
`else
  assign misaligned = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      half_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      half_q  <= half_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    half_d      = half_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    req_ready   = 1'b0;
    resp_valid  = 1'b0;
    resp_rdata  = '0;
    resp_err    = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_address = '0;
    mem_wdata   = '0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          we_d    = req_we;
          half_d  = req_half;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          rdata_d = '0;
          err_d   = misaligned;
          state_d = misaligned ? RESP : ACC0;
        end
      end
      ACC0: begin
        mem_address = addr_q;
        if (we_q) begin
          mem_write = 1'b1;
          mem_wdata = wdata_q[7:0];
        end else begin
          mem_read      = 1'b1;
          rdata_d[7:0]  = mem_rdata;
        end
        state_d = half_q ? ACC1 : RESP;
      end
      ACC1: begin
        // Upper byte lives at the next address; the adder wraps at the top of memory.
        mem_address = addr_q + ADDR_W'(1);
        if (we_q) begin
          mem_write = 1'b1;
          mem_wdata = wdata_q[15:8];
        end else begin
          mem_read      = 1'b1;
          rdata_d[15:8] = mem_rdata;
        end
        state_d = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_rdata = rdata_q;
        resp_err   = err_q;
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios plus random traffic against a byte-array model.
// Build with LSU_ALIGN_CHECK_EN defined to exercise the alignment-check variant.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we, req_half;
  logic [7:0]  req_addr;
  logic [15:0] req_wdata;
  logic        resp_valid, resp_ready;
  logic [15:0] resp_rdata;
  logic        resp_err;
  logic        mem_read, mem_write;
  logic [7:0]  mem_address, mem_wdata, mem_rdata;

  logic [7:0]  mem [256];
  logic [7:0]  ref_mem [256];
  logic        mem_init;

  int checks = 0;
  int failures = 0;

  logic txn_active = 1'b0;
  logic txn_we = 1'b0;
  logic txn_misal = 1'b0;

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_W(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_half(req_half),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Byte memory; returns a junk pattern when not read so stray sampling shows up.
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'((i * 37 + 11) & 8'hFF);
    end else if (mem_write) begin
      mem[mem_address] <= mem_wdata;
    end
  end
  assign mem_rdata = mem_read ? mem[mem_address] : 8'hC3;

  // Per-cycle bus protocol checks.
  always @(negedge clk) begin
    if (!rst && !mem_init) begin
      checks++;
      if (mem_read && mem_write) begin
        failures++;
        $display("FAIL bus_exclusive: mem_read=%b mem_write=%b required not both 1", mem_read, mem_write);
      end else if (mem_read && !(txn_active && !txn_we && !txn_misal)) begin
        failures++;
        $display("FAIL read_only_in_load: mem_read=1 required 0 (active=%b we=%b)", txn_active, txn_we);
      end else if (mem_write && !(txn_active && txn_we && !txn_misal)) begin
        failures++;
        $display("FAIL write_only_in_store: mem_write=1 required 0 (active=%b we=%b)", txn_active, txn_we);
      end else if ((resp_valid || req_ready) && (mem_read || mem_write || mem_address != 8'h00 || mem_wdata != 8'h00)) begin
        failures++;
        $display("FAIL idle_bus: rd=%b wr=%b addr=%h wdata=%h required all 0", mem_read, mem_write, mem_address, mem_wdata);
      end
    end
  end

  function automatic logic is_misal(input logic half, input logic [7:0] a);
`ifdef LSU_ALIGN_CHECK_EN
    return half & a[0];
`else
    return half & a[0] & 1'b0;
`endif
  endfunction

  task automatic do_req(input logic we, input logic half, input logic [7:0] addr,
                        input logic [15:0] wdata, input int hold, input string name);
    logic [15:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          n;
    logic        misal;
    logic [7:0]  a1;
    logic [15:0] held;
    a1    = addr + 8'd1;
    misal = is_misal(half, addr);
    if (misal) begin
      exp_rdata = 16'h0000; exp_err = 1'b1; exp_lat = 1;
    end else begin
      exp_err = 1'b0;
      exp_lat = half ? 3 : 2;
      if (we) exp_rdata = 16'h0000;
      else if (half) exp_rdata = {ref_mem[a1], ref_mem[addr]};
      else exp_rdata = {8'h00, ref_mem[addr]};
    end

    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s_ready: req_ready=%b required 1", name, req_ready);
    end
    req_valid = 1'b1; req_we = we; req_half = half; req_addr = addr; req_wdata = wdata;
    txn_active = 1'b1; txn_we = we; txn_misal = misal;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
      if (n == 1) begin
        req_valid = 1'b0; req_wdata = $urandom; req_addr = $urandom;
      end
    end while (resp_valid !== 1'b1 && n < 10);

    checks++;
    if (n != exp_lat) begin
      failures++;
      $display("FAIL %s_latency: got %0d cycles required %0d", name, n, exp_lat);
    end
    checks++;
    if (resp_rdata !== exp_rdata) begin
      failures++;
      $display("FAIL %s_rdata: got %h required %h", name, resp_rdata, exp_rdata);
    end
    checks++;
    if (resp_err !== exp_err) begin
      failures++;
      $display("FAIL %s_err: got %b required %b", name, resp_err, exp_err);
    end

    held = resp_rdata;
    for (int c = 0; c < hold; c++) begin
      @(negedge clk);
      checks++;
      if (resp_valid !== 1'b1 || resp_rdata !== held || req_ready !== 1'b0 || mem_read || mem_write) begin
        failures++;
        $display("FAIL %s_hold: valid=%b rdata=%h ready=%b rd=%b wr=%b required 1 %h 0 0 0",
                 name, resp_valid, resp_rdata, req_ready, mem_read, mem_write, held);
      end
    end

    @(negedge clk);
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    txn_active = 1'b0;
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      failures++;
      $display("FAIL %s_release: req_ready=%b resp_valid=%b required 1 0", name, req_ready, resp_valid);
    end

    if (we && !misal) begin
      ref_mem[addr] = wdata[7:0];
      if (half) ref_mem[a1] = wdata[15:8];
    end
    $display("txn %s we=%b half=%b addr=%h wdata=%h -> rdata=%h err=%b lat=%0d", name, we, half, addr, wdata, held, exp_err, n);
  endtask

  task automatic check_mem(input logic [7:0] a, input logic [7:0] exp, input string name);
    checks++;
    if (mem[a] !== exp) begin
      failures++;
      $display("FAIL %s: mem[%h]=%h required %h", name, a, mem[a], exp);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_rdata !== 16'h0 || resp_err !== 1'b0 ||
        mem_read !== 1'b0 || mem_write !== 1'b0 || mem_address !== 8'h0 || mem_wdata !== 8'h0) begin
      failures++;
      $display("FAIL %s: rdy=%b vld=%b rdata=%h err=%b rd=%b wr=%b addr=%h wd=%h required 1 0 0000 0 0 0 00 00",
               name, req_ready, resp_valid, resp_rdata, resp_err, mem_read, mem_write, mem_address, mem_wdata);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; mem_init = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_half = 1'b0; req_addr = 8'h00; req_wdata = 16'h0;
    resp_ready = 1'b0;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'((i * 37 + 11) & 8'hFF);
    repeat (3) @(negedge clk);
    check_reset_outputs("reset_state");
    mem_init = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("post_reset_idle");
  endtask

  task automatic test_byte();
    do_req(1'b1, 1'b0, 8'h10, 16'h77A5, 0, "byte_store");
    check_mem(8'h10, 8'hA5, "byte_store_mem");
    do_req(1'b0, 1'b0, 8'h10, 16'h0, 0, "byte_load");
  endtask

  task automatic test_halfword();
    do_req(1'b1, 1'b1, 8'h20, 16'hBEEF, 0, "half_store");
    check_mem(8'h20, 8'hEF, "half_store_lo");
    check_mem(8'h21, 8'hBE, "half_store_hi");
    do_req(1'b0, 1'b0, 8'h20, 16'h0, 0, "byte_load_20");
    do_req(1'b0, 1'b0, 8'h21, 16'h0, 0, "byte_load_21");
    do_req(1'b0, 1'b1, 8'h20, 16'h0, 0, "half_load_20");
  endtask

  task automatic test_wrap();
    logic [7:0] old_ff, old_00;
    old_ff = ref_mem[8'hFF];
    old_00 = ref_mem[8'h00];
    do_req(1'b1, 1'b1, 8'hFF, 16'h1234, 0, "wrap_store");
`ifdef LSU_ALIGN_CHECK_EN
    check_mem(8'hFF, old_ff, "wrap_unchanged_ff");
    check_mem(8'h00, old_00, "wrap_unchanged_00");
`else
    check_mem(8'hFF, 8'h34, "wrap_lo");
    check_mem(8'h00, 8'h12, "wrap_hi");
    if (old_ff == 8'h34 && old_00 == 8'h12) $display("note: wrap target already held data");
`endif
    do_req(1'b0, 1'b1, 8'hFF, 16'h0, 0, "wrap_load");
  endtask

  task automatic test_backpressure();
    do_req(1'b0, 1'b1, 8'h20, 16'h0, 5, "bp_half_load");
    do_req(1'b1, 1'b0, 8'h30, 16'h005C, 5, "bp_byte_store");
  endtask

  task automatic test_reset_mid_store();
    logic [7:0] old41;
    old41 = ref_mem[8'h41];
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_half = 1'b1; req_addr = 8'h40; req_wdata = 16'hCAFE;
    txn_active = 1'b1; txn_we = 1'b1; txn_misal = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (mem_write !== 1'b1 || mem_address !== 8'h41 || mem_wdata !== 8'hCA) begin
      failures++;
      $display("FAIL rst_acc1: wr=%b addr=%h wdata=%h required 1 41 ca", mem_write, mem_address, mem_wdata);
    end
    #1 rst = 1'b1;
    #1;
    check_reset_outputs("rst_mid_store");
    txn_active = 1'b0;
    @(negedge clk);
    check_mem(8'h40, 8'hFE, "rst_lo_written");
    check_mem(8'h41, old41, "rst_hi_untouched");
    ref_mem[8'h40] = 8'hFE;
    rst = 1'b0;
    $display("txn rst_mid_store addr=40 wdata=cafe aborted in ACC1");
    do_req(1'b0, 1'b1, 8'h40, 16'h0, 0, "after_rst_load");
    do_req(1'b1, 1'b0, 8'h41, 16'h0033, 0, "after_rst_store");
    check_mem(8'h41, 8'h33, "after_rst_mem");
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      do_req(1'($urandom), 1'($urandom), 8'($urandom), 16'($urandom), $urandom_range(0, 2), "rand");
    end
  endtask

  initial begin
    test_reset();
    test_byte();
    test_halfword();
    test_wrap();
    test_backpressure();
    test_reset_mid_store();
    test_random();
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
